i2s_rx: RTL and testbench

- Serial-to-parallel receiver for a Philips-format I2S stream, clocked by the I2S bit clock.
- Recovers left/right words from ws/sd and presents each as a parallel word with a one-cycle channel-valid pulse.
- Feeds the loopback/latch stage directly through its data, l_vld and r_vld inputs. Port names and semantics here match that stage one-to-one.
- Handles slot widths shorter or longer than DATA_WIDTH, and resynchronises after reset or disable.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_rx.sv | 113 +++++++++++
 tb/tb_i2s_rx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive path and the loopback/latch stage.
// Holds the receiver FSM encoding and the word-select channel constants.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_HUNT  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx.sv
// Philips-format I2S receiver clocked by the bit clock: rebuilds left/right words
// from ws/sd and pulses l_vld or r_vld for one cycle when a slot completes.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SLOT_MAX   = 32
) (
    input  logic                  sck,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  ws,
    input  logic                  sd,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  l_vld,
    output logic                  r_vld,
    output logic                  slot_err
);

    localparam int              CW      = $clog2(SLOT_MAX + 1);
    localparam logic [CW-1:0]   CNT_SAT = CW'(SLOT_MAX + 1);

    state_t                state;
    state_t                state_nx;
    logic                  ws_d;
    logic                  trans;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] sh_nx;
    logic [DATA_WIDTH-1:0] word;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nx;
    logic                  emit;
    logic                  err_nx;
    int                    cnt_inc;

    // The bit sampled on a ws change is the LSB of the slot that is ending.
    assign trans = ws ^ ws_d;

    always_ff @(posedge sck) begin
        if (rst) begin
            state <= ST_PRIME;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = ST_PRIME;
        end else begin
            case (state)
                ST_PRIME: state_nx = ST_HUNT;
                ST_HUNT:  state_nx = trans ? ST_RUN : ST_HUNT;
                ST_RUN:   state_nx = ST_RUN;
                default:  state_nx = ST_PRIME;
            endcase
        end
    end

    always_comb begin
        word = sh;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (int'(cnt) == DATA_WIDTH - 1 - i) begin
                word[i] = sd;
            end
        end
        cnt_inc = int'(cnt) + 1;
        err_nx  = (cnt_inc < DATA_WIDTH) || (cnt_inc > SLOT_MAX);
        emit    = en && (state == ST_RUN) && trans;
        sh_nx   = sh;
        cnt_nx  = cnt;
        if (!en) begin
            sh_nx  = '0;
            cnt_nx = '0;
        end else if (state == ST_HUNT && trans) begin
            sh_nx  = '0;
            cnt_nx = '0;
        end else if (state == ST_RUN) begin
            if (trans) begin
                sh_nx  = '0;
                cnt_nx = '0;
            end else begin
                sh_nx  = word;
                // Saturate so an over-long slot can never wrap back into range.
                cnt_nx = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            ws_d     <= 1'b0;
            sh       <= '0;
            cnt      <= '0;
            data     <= '0;
            l_vld    <= 1'b0;
            r_vld    <= 1'b0;
            slot_err <= 1'b0;
        end else begin
            ws_d     <= ws;
            sh       <= sh_nx;
            cnt      <= cnt_nx;
            l_vld    <= emit && (ws_d == WS_LEFT);
            r_vld    <= emit && (ws_d == WS_RIGHT);
            slot_err <= emit && err_nx;
            if (emit) begin
                data <= word;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: slot vectors with hand-computed words, plus
// enable-drop and reset-on-transition sequences.
module tb_i2s_rx;
    import i2s_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       ws  = 1'b0;
    logic       sd  = 1'b0;
    logic [7:0] data;
    logic       l_vld;
    logic       r_vld;
    logic       slot_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    i2s_rx #(.DATA_WIDTH(8), .SLOT_MAX(32)) dut (
        .sck(clk), .rst(rst), .en(en), .ws(ws), .sd(sd),
        .data(data), .l_vld(l_vld), .r_vld(r_vld), .slot_err(slot_err)
    );

    typedef struct {
        logic        ch;
        int          width;
        logic [63:0] word;
        logic        exp_vld;
        logic [7:0]  exp_data;
        logic        exp_err;
        logic        chk_data;
        int          en_lo_a;
        int          en_lo_n;
        int          rst_a;
        int          rst_n;
    } slot_t;

    slot_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic s, input logic e, input logic r);
        @(negedge clk);
        ws  = w;
        sd  = s;
        en  = e;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    // Bits go MSB first; ws flips to the other channel on the LSB (Philips timing).
    task automatic send_slot(input slot_t v, input string tag);
        int   spur;
        logic lsb;
        logic e;
        logic r;
        spur = 0;
        for (int i = 0; i < v.width; i++) begin
            lsb = (i == v.width - 1);
            e   = !(i >= v.en_lo_a && i < v.en_lo_a + v.en_lo_n);
            r   = (i >= v.rst_a && i < v.rst_a + v.rst_n);
            drive(lsb ? ~v.ch : v.ch, v.word[v.width-1-i], e, r);
            if (!lsb || !v.exp_vld) begin
                if (l_vld || r_vld || slot_err) spur++;
            end else begin
                check({tag, " data"},     64'(data),     64'(v.exp_data));
                check({tag, " l_vld"},    64'(l_vld),    64'(v.ch == WS_LEFT));
                check({tag, " r_vld"},    64'(r_vld),    64'(v.ch == WS_RIGHT));
                check({tag, " slot_err"}, 64'(slot_err), 64'(v.exp_err));
            end
        end
        check({tag, " spurious"}, 64'(spur), 64'(0));
        if (!v.exp_vld && v.chk_data) begin
            check({tag, " held data"}, 64'(data), 64'(v.exp_data));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        slot_t s;
        // ch, width, word, exp_vld, exp_data, exp_err, chk_data, en_lo_a, en_lo_n, rst_a, rst_n
        vecs[0]  = '{1'b1, 16, 64'h3C0F,        1'b0, 8'h00, 1'b0, 1'b0, -1, 0,  0, 4};
        vecs[1]  = '{1'b0, 16, 64'hA5C3,        1'b1, 8'hA5, 1'b0, 1'b0, -1, 0, -1, 0};
        vecs[2]  = '{1'b1, 16, 64'h3C0F,        1'b1, 8'h3C, 1'b0, 1'b0, -1, 0, -1, 0};
        for (int k = 0; k < 4; k++) begin
            vecs[3+2*k] = '{1'b0, 8, 64'h81, 1'b1, 8'h81, 1'b0, 1'b0, -1, 0, -1, 0};
            vecs[4+2*k] = '{1'b1, 8, 64'h7E, 1'b1, 8'h7E, 1'b0, 1'b0, -1, 0, -1, 0};
        end
        vecs[11] = '{1'b0,  6, 64'h2D,          1'b1, 8'hB4, 1'b1, 1'b0, -1, 0, -1, 0};
        vecs[12] = '{1'b1, 40, 64'hE7_0000_0001, 1'b1, 8'hE7, 1'b1, 1'b0, -1, 0, -1, 0};
        vecs[13] = '{1'b0, 16, 64'h1234,        1'b1, 8'h12, 1'b0, 1'b0, -1, 0, -1, 0};
        vecs[14] = '{1'b1, 32, 64'hDEAD_BEEF,   1'b1, 8'hDE, 1'b0, 1'b0, -1, 0, -1, 0};
        vecs[15] = '{1'b0, 33, 64'h1_2345_6789, 1'b1, 8'h91, 1'b1, 1'b0, -1, 0, -1, 0};
        vecs[16] = '{1'b1,  8, 64'h42,          1'b1, 8'h42, 1'b0, 1'b0, -1, 0, -1, 0};

        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("reset data",     64'(data),     64'(0));
        check("reset l_vld",    64'(l_vld),    64'(0));
        check("reset r_vld",    64'(r_vld),    64'(0));
        check("reset slot_err", 64'(slot_err), 64'(0));

        for (int i = 0; i < 17; i++) begin
            send_slot(vecs[i], $sformatf("slot%0d", i));
        end

        // en low for 3 bits mid-slot: that slot is lost, the next full one is reported.
        s = '{1'b0, 16, 64'hFFFF, 1'b0, 8'h42, 1'b0, 1'b1, 5, 3, -1, 0};
        send_slot(s, "en_drop");
        s = '{1'b1, 16, 64'h3C0F, 1'b1, 8'h3C, 1'b0, 1'b0, -1, 0, -1, 0};
        send_slot(s, "after_en");

        // rst on the completing edge of 0x5A, then PRIME/HUNT before the next word.
        s = '{1'b0, 8, 64'h5A, 1'b0, 8'h00, 1'b0, 1'b1, -1, 0, 7, 1};
        send_slot(s, "rst_on_ws");
        s = '{1'b1, 8, 64'hC3, 1'b0, 8'h00, 1'b0, 1'b1, -1, 0, -1, 0};
        send_slot(s, "rst_hunt");
        s = '{1'b0, 8, 64'h11, 1'b1, 8'h11, 1'b0, 1'b0, -1, 0, -1, 0};
        send_slot(s, "rst_first");
        s = '{1'b1, 8, 64'h99, 1'b1, 8'h99, 1'b0, 1'b0, -1, 0, -1, 0};
        send_slot(s, "rst_second");

        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("idle vld", 64'(l_vld | r_vld | slot_err), 64'(0));
        check("idle data", 64'(data), 64'(8'h99));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
